// File: rtl/read_iq_pkg.sv
// Shared globals for the IQ sample path.
// DATA_SIZE : width of a quantized sample word written to the I/Q FIFOs.
// BITS      : default left-shift applied to each raw 16-bit sample.
// QUANTIZE  : sign-extends a raw 16-bit sample to DATA_SIZE and shifts it left.
package read_iq_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned BITS      = 10;

  // No rounding or saturation: bits shifted past the MSB are dropped.
  function automatic logic [DATA_SIZE-1:0] QUANTIZE(input logic [15:0]   sample,
                                                    input int unsigned   shift);
    logic [DATA_SIZE-1:0] ext;
    ext = {{(DATA_SIZE-16){sample[15]}}, sample};
    return ext << shift;
  endfunction

endpackage

// File: rtl/read_iq.sv
// read_iq: unpacks a byte stream (I lo, I hi, Q lo, Q hi) from a FWFT byte FIFO
// into quantized I/Q samples and writes them as a pair to two output FIFOs.
// Ports:
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   in_dout, in_empty          : head byte / empty flag of the upstream FIFO
//   in_rd_en                   : pops the head byte in the cycle it is high
//   i_out_din/full/wr_en       : real (in-phase) output FIFO interface
//   q_out_din/full/wr_en       : imag (quadrature) output FIFO interface
module read_iq
  import read_iq_pkg::*;
#(
  parameter int unsigned QUANT_BITS = BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_dout,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  input  logic                 i_out_full,
  output logic                 i_out_wr_en,
  output logic [DATA_SIZE-1:0] q_out_din,
  input  logic                 q_out_full,
  output logic                 q_out_wr_en
);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [1:0]      byte_cnt;
  logic [3:0][7:0] bytes_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_READ;
      byte_cnt  <= '0;
      bytes_q   <= '0;
      i_out_din <= '0;
      q_out_din <= '0;
    end else begin
      state <= state_next;
      if (in_rd_en) begin
        bytes_q[byte_cnt] <= in_dout;
        byte_cnt          <= byte_cnt + 2'd1;
        // Byte 3 is still on in_dout, so the pair is built from the stored
        // slots plus the live head byte; outputs are ready on S_WRITE entry.
        if (byte_cnt == 2'd3) begin
          i_out_din <= QUANTIZE({bytes_q[1], bytes_q[0]}, QUANT_BITS);
          q_out_din <= QUANTIZE({in_dout, bytes_q[2]}, QUANT_BITS);
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    in_rd_en    = 1'b0;
    i_out_wr_en = 1'b0;
    q_out_wr_en = 1'b0;
    // Strobes are gated by reset so nothing is popped or written while held.
    if (!reset) begin
      case (state)
        S_READ: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (byte_cnt == 2'd3) state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (!i_out_full && !q_out_full) begin
            i_out_wr_en = 1'b1;
            q_out_wr_en = 1'b1;
            state_next  = S_READ;
          end
        end
        default: state_next = S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
module tb_read_iq;
  import read_iq_pkg::*;

  logic                 clock;
  logic                 reset;
  logic [7:0]           in_dout;
  logic                 in_empty;
  logic                 in_rd_en;
  logic [DATA_SIZE-1:0] i_out_din;
  logic                 i_out_full;
  logic                 i_out_wr_en;
  logic [DATA_SIZE-1:0] q_out_din;
  logic                 q_out_full;
  logic                 q_out_wr_en;

  read_iq #(.QUANT_BITS(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .i_out_din  (i_out_din),
    .i_out_full (i_out_full),
    .i_out_wr_en(i_out_wr_en),
    .q_out_din  (q_out_din),
    .q_out_full (q_out_full),
    .q_out_wr_en(q_out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo[$];
  logic [31:0] wr_i[$];
  logic [31:0] wr_q[$];
  int          wr_cyc[$];
  int          cycle   = 0;
  int          pops    = 0;
  int          lone_wr = 0;
  logic        ifull   = 1'b0;
  logic        qfull   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the negedge, observe strobes, advance.
  task automatic tick();
    in_empty   = (fifo.size() == 0);
    in_dout    = (fifo.size() != 0) ? fifo[0] : 8'h00;
    i_out_full = ifull;
    q_out_full = qfull;
    #1;
    if (in_rd_en) begin
      pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if (i_out_wr_en && q_out_wr_en) begin
      wr_i.push_back(i_out_din);
      wr_q.push_back(q_out_din);
      wr_cyc.push_back(cycle);
    end else if (i_out_wr_en || q_out_wr_en) begin
      lone_wr++;
    end
    cycle++;
    @(negedge clock);
  endtask

  task automatic clear_log();
    wr_i.delete();
    wr_q.delete();
    wr_cyc.delete();
    pops  = 0;
    cycle = 0;
  endtask

  task automatic run_until_writes(input int n, input int limit);
    while (wr_i.size() < n && cycle < limit) tick();
  endtask

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    fifo.push_back(b0);
    fifo.push_back(b1);
    fifo.push_back(b2);
    fifo.push_back(b3);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fifo.delete();
    in_empty = 1'b0;
    in_dout  = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
      check("rst_wr_en", {30'd0, i_out_wr_en, q_out_wr_en}, 32'd0);
      @(negedge clock);
    end
    reset = 1'b0;
  endtask

  function automatic logic [31:0] ref_q(input logic [7:0] lo, input logic [7:0] hi);
    logic signed [31:0] s;
    s = $signed({hi, lo});
    return s * 32'sd1024;
  endfunction

  initial begin
    reset = 1'b1; in_empty = 1'b1; in_dout = '0; i_out_full = 1'b0; q_out_full = 1'b0;
    @(negedge clock);

    // Reset state
    do_reset();
    check("rst_i_din", i_out_din, 32'h0);
    check("rst_q_din", q_out_din, 32'h0);

    // Basic pair, back-to-back bytes
    clear_log();
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    run_until_writes(1, 20);
    repeat (4) tick();
    check("basic_nwr", wr_i.size(), 1);
    if (wr_i.size() >= 1) begin
      check("basic_i", wr_i[0], 32'h0048D000);
      check("basic_q", wr_q[0], 32'hFEAF3400);
      check("basic_lat", wr_cyc[0], 4);
    end
    check("basic_hold_i", i_out_din, 32'h0048D000);
    check("basic_pops", pops, 4);

    // Extremes / sign extension
    clear_log();
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    run_until_writes(1, 20);
    check("ext_nwr", wr_i.size(), 1);
    if (wr_i.size() >= 1) begin
      check("ext_i", wr_i[0], 32'hFE000000);
      check("ext_q", wr_q[0], 32'h01FFFC00);
    end

    // Input stall of 7 cycles between b1 and b2
    clear_log();
    fifo.push_back(8'h34);
    fifo.push_back(8'h12);
    repeat (9) tick();
    check("stall_pops", pops, 2);
    check("stall_nowr", wr_i.size(), 0);
    fifo.push_back(8'hCD);
    fifo.push_back(8'hAB);
    run_until_writes(1, 30);
    check("stall_nwr", wr_i.size(), 1);
    if (wr_i.size() >= 1) begin
      check("stall_i", wr_i[0], 32'h0048D000);
      check("stall_q", wr_q[0], 32'hFEAF3400);
      check("stall_lat", wr_cyc[0], 11);
    end

    // Output back-pressure on the imag FIFO for 10 cycles
    clear_log();
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    push4(8'h34, 8'h12, 8'hCD, 8'hAB);
    qfull = 1'b1;
    repeat (14) tick();
    check("full_nowr", wr_i.size(), 0);
    check("full_pops", pops, 4);
    qfull = 1'b0;
    run_until_writes(2, 40);
    check("full_nwr", wr_i.size(), 2);
    if (wr_i.size() >= 2) begin
      check("full_i", wr_i[0], 32'hFE000000);
      check("full_q", wr_q[0], 32'h01FFFC00);
      check("full_lat", wr_cyc[0], 14);
      check("full_i2", wr_i[1], 32'h0048D000);
    end

    // Reset mid-word discards the partial pair
    clear_log();
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    repeat (2) tick();
    do_reset();
    check("mid_rst_i", i_out_din, 32'h0);
    clear_log();
    push4(8'h78, 8'h56, 8'h00, 8'h80);
    run_until_writes(1, 20);
    repeat (3) tick();
    check("mid_nwr", wr_i.size(), 1);
    if (wr_i.size() >= 1) begin
      check("mid_i", wr_i[0], 32'h0159E000);
      check("mid_q", wr_q[0], 32'hFE000000);
    end

    // Reset while a pair is pending in S_WRITE
    clear_log();
    ifull = 1'b1;
    push4(8'h01, 8'h00, 8'h02, 8'h00);
    repeat (6) tick();
    do_reset();
    ifull = 1'b0;
    clear_log();
    repeat (5) tick();
    check("wr_rst_nowr", wr_i.size(), 0);

    // Random stream, 100 pairs against the reference model
    begin
      logic [7:0]  rb[400];
      logic [31:0] ei[100];
      logic [31:0] eq[100];
      int          bad;
      clear_log();
      for (int k = 0; k < 400; k++) begin
        rb[k] = 8'($urandom_range(0, 255));
        fifo.push_back(rb[k]);
      end
      for (int k = 0; k < 100; k++) begin
        ei[k] = ref_q(rb[4*k],   rb[4*k+1]);
        eq[k] = ref_q(rb[4*k+2], rb[4*k+3]);
      end
      run_until_writes(100, 600);
      check("rand_nwr", wr_i.size(), 100);
      check("rand_done", {31'd0, (cycle <= 500)}, 32'd1);
      bad = 0;
      for (int k = 0; k < 100 && k < wr_i.size(); k++) begin
        if (wr_i[k] !== ei[k] || wr_q[k] !== eq[k]) begin
          if (bad < 4) begin
            check("rand_i", wr_i[k], ei[k]);
            check("rand_q", wr_q[k], eq[k]);
          end
          bad++;
        end
      end
      check("rand_bad", bad, 0);
    end

    check("lone_wr", lone_wr, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/read_iq.md
READ_IQ -- requirements
Module: read_iq

Interface
REQ-001 Parameter QUANT_BITS, default BITS from the shared package (10): left-shift applied to each raw 16-bit sample.
REQ-002 Port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port in_dout  input  8  head byte of the upstream byte FIFO (first-word-fall-through, valid while in_empty=0).
REQ-005 Port in_empty  input  1  upstream FIFO empty flag.
REQ-006 Port in_rd_en  output  1  pops one byte in the same cycle it is asserted.
REQ-007 Port i_out_din  output  DATA_SIZE  quantized in-phase (real) sample for the real FIFO.
REQ-008 Port i_out_full  input  1  real output FIFO full flag.
REQ-009 Port i_out_wr_en  output  1  real FIFO write strobe.
REQ-010 Port q_out_din  output  DATA_SIZE  quantized quadrature (imag) sample for the imag FIFO.
REQ-011 Port q_out_full  input  1  imag output FIFO full flag.
REQ-012 Port q_out_wr_en  output  1  imag FIFO write strobe.

Function
REQ-013 Byte stream order per sample pair: b0=I[7:0], b1=I[15:8], b2=Q[7:0], b3=Q[15:8].
REQ-014 Two-state FSM: S_READ (collect bytes) and S_WRITE (emit pair); any illegal encoding returns to S_READ.
REQ-015 S_READ: when in_empty=0, assert in_rd_en, latch in_dout into byte slot byte_cnt, increment the 2-bit byte_cnt.
REQ-016 S_READ with in_empty=1: in_rd_en=0, byte_cnt and captured bytes held (stall mid-word, no timeout).
REQ-017 On the pop of byte 3 (byte_cnt=3), byte_cnt wraps to 0 and the FSM moves to S_WRITE next cycle.
REQ-018 Arithmetic: sample = sign-extend {hi,lo} (16-bit signed) to DATA_SIZE, then shift left QUANT_BITS; no rounding, no saturation.
REQ-019 i_out_din/q_out_din are registered and hold the last computed pair until the next pair is complete.
REQ-020 S_WRITE: when i_out_full=0 AND q_out_full=0, assert i_out_wr_en and q_out_wr_en together for exactly one cycle, then return to S_READ.
REQ-021 S_WRITE with either full flag high: both wr_en held 0, data held, FSM stays in S_WRITE; a single wr_en is never asserted.
REQ-022 in_rd_en is 0 in S_WRITE; wr_en signals are 0 in S_READ.
REQ-023 Latency: wr_en asserted the cycle after byte 3 is popped if both outputs not full; peak throughput one pair per 5 clocks.

Reset
REQ-024 reset=1 at a clock edge: state=S_READ, byte_cnt=0, byte slots=0, i_out_din=q_out_din=0.
REQ-025 During and after reset: in_rd_en, i_out_wr_en, q_out_wr_en = 0 until reset deasserts.
REQ-026 Reset mid-word or in S_WRITE discards the partial/pending pair; the next byte after reset is treated as b0.

Structure
REQ-027 DATA_SIZE, BITS and the QUANTIZE function live in the shared globals package; this block imports them, defines no new global constants.
REQ-028 Single flat module; no sub-module, FIFOs instantiated by the top level.

Verification
REQ-029 Bytes 0x34,0x12,0xCD,0xAB back-to-back -> one write, i_out_din=0x0048D000, q_out_din=0xFEAF3400, wr_en high exactly one cycle.
REQ-030 Bytes 0x00,0x80,0xFF,0x7F -> i_out_din=0xFE000000, q_out_din=0x01FFFC00 (extremes, sign extension).
REQ-031 in_empty high for 7 cycles between b1 and b2 -> no extra pops, same output as REQ-029, write delayed 7 cycles.
REQ-032 q_out_full=1 for 10 cycles at S_WRITE entry -> both wr_en 0 throughout, single paired write when released, no byte popped meanwhile.
REQ-033 reset pulse after b1 popped, then full 4-byte word -> only the post-reset pair written, values per REQ-018.
REQ-034 400 random bytes streamed with empty/full never asserted -> 100 pairs matching a reference model, completed within 500 cycles.
